dynamic_piso_serializer: RTL and testbench

DYNAMIC_PISO_SERIALIZER -- requirements
Module: dynamic_piso_serializer

---
 rtl/dynamic_piso_serializer_pkg.sv | 12 +
 rtl/dynamic_piso_serializer_datapath.sv | 41 ++++
 rtl/dynamic_piso_serializer.sv | 82 ++++++++
 tb/tb_dynamic_piso_serializer.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/dynamic_piso_serializer_pkg.sv
// Shared parameters and state encoding for the variable-length PISO serializer.
package dynamic_piso_serializer_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int AW_DEF    = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } piso_state_t;

endpackage

// File: rtl/dynamic_piso_serializer_datapath.sv
// Shift register with programmable tap and remaining-bit down-counter.
module piso_datapath
    import dynamic_piso_serializer_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] pdata,
    input  logic [AW-1:0]    a,
    output logic             q,
    output logic             cnt_zero
);

    logic [WIDTH-1:0] shift_reg;
    logic [AW-1:0]    tap;
    logic [AW-1:0]    cnt;

    // Load takes priority over shift so a word captured on the final-bit edge starts clean.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            shift_reg <= '0;
            tap       <= '0;
            cnt       <= '0;
        end else if (load) begin
            shift_reg <= pdata;
            tap       <= a;
            cnt       <= a;
        end else if (shift) begin
            shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
            cnt       <= cnt - AW'(1);
        end
    end

    assign q        = shift_reg[tap];
    assign cnt_zero = (cnt == '0);

endmodule

// File: rtl/dynamic_piso_serializer.sv
// Variable-length parallel-in serial-out serializer with valid/ready load handshake.
//
// state | meaning
// IDLE  | no word in flight, ready for a load
// SHIFT | presenting bits of the current word on Q, MSB of field first
module dynamic_piso_serializer
    import dynamic_piso_serializer_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             CE,
    input  logic [WIDTH-1:0] PDATA,
    input  logic [AW-1:0]    A,
    input  logic             LOAD_VALID,
    output logic             LOAD_READY,
    output logic             Q,
    output logic             Q_VALID,
    output logic             LAST
);

    piso_state_t state, state_nxt;
    logic        load;
    logic        shift;
    logic        dp_q;
    logic        cnt_zero;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        LOAD_READY = 1'b0;
        Q_VALID    = 1'b0;
        LAST       = 1'b0;
        Q          = 1'b0;
        case (state)
            IDLE: begin
                LOAD_READY = RST_N;
                if (LOAD_VALID && RST_N) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                Q_VALID    = 1'b1;
                Q          = dp_q;
                LAST       = cnt_zero;
                // Ready only on the final-bit edge so the next word follows without a gap.
                LOAD_READY = RST_N && cnt_zero && CE;
                if (cnt_zero && CE && !LOAD_VALID) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign load  = LOAD_VALID && LOAD_READY;
    assign shift = (state == SHIFT) && CE;

    piso_datapath #(
        .WIDTH (WIDTH),
        .AW    (AW)
    ) u_datapath (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .load     (load),
        .shift    (shift),
        .pdata    (PDATA),
        .a        (A),
        .q        (dp_q),
        .cnt_zero (cnt_zero)
    );

endmodule

// File: tb/tb_dynamic_piso_serializer.sv
// Scoreboard bench for dynamic_piso_serializer: expected bits queued at load, popped as shifted.
module tb_dynamic_piso_serializer;

    typedef struct packed {
        logic q;
        logic last;
    } bit_t;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        CE;
    logic [15:0] PDATA;
    logic [3:0]  A;
    logic        LOAD_VALID;
    logic        LOAD_READY;
    logic        Q;
    logic        Q_VALID;
    logic        LAST;

    bit_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 CLK = ~CLK;

    dynamic_piso_serializer dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .CE         (CE),
        .PDATA      (PDATA),
        .A          (A),
        .LOAD_VALID (LOAD_VALID),
        .LOAD_READY (LOAD_READY),
        .Q          (Q),
        .Q_VALID    (Q_VALID),
        .LAST       (LAST)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Called at a falling edge: check outputs, drive inputs, update the model for the coming rising edge.
    task automatic step(input bit rst_n_i, input bit ce_i, input bit lv_i,
                        input logic [15:0] pd, input logic [3:0] a_i);
        bit   exp_ready;
        bit_t hd;
        if (sb.size() != 0) begin
            hd = sb[0];
            chk("q_valid", 32'(Q_VALID), 32'(1));
            chk("q", 32'(Q), 32'(hd.q));
            chk("last", 32'(LAST), 32'(hd.last));
        end else begin
            chk("q_valid_idle", 32'(Q_VALID), 32'(0));
            chk("q_idle", 32'(Q), 32'(0));
            chk("last_idle", 32'(LAST), 32'(0));
        end
        RST_N      = rst_n_i;
        CE         = ce_i;
        LOAD_VALID = lv_i;
        PDATA      = lv_i ? pd  : 16'($urandom);
        A          = lv_i ? a_i : 4'($urandom);
        #1;
        exp_ready = rst_n_i && (sb.size() == 0 || (sb[0].last && ce_i));
        chk("load_ready", 32'(LOAD_READY), 32'(exp_ready));
        if (!rst_n_i) begin
            sb.delete();
        end else begin
            if (sb.size() != 0 && ce_i) void'(sb.pop_front());
            if (lv_i && exp_ready) begin
                for (int k = 0; k <= int'(a_i); k++) begin
                    hd.q    = pd[int'(a_i) - k];
                    hd.last = (k == int'(a_i));
                    sb.push_back(hd);
                end
            end
        end
        @(negedge CLK);
    endtask

    task automatic run(input int n, input bit ce_i);
        for (int i = 0; i < n; i++) step(1'b1, ce_i, 1'b0, 16'h0, 4'h0);
    endtask

    initial begin
        RST_N      = 1'b0;
        CE         = 1'b0;
        LOAD_VALID = 1'b0;
        PDATA      = '0;
        A          = '0;
        repeat (2) @(negedge CLK);

        // reset overrides a load attempt; ready held low
        step(1'b0, 1'b1, 1'b1, 16'hFFFF, 4'hF);
        run(1, 1'b1);

        // A5C3, A=7
        step(1'b1, 1'b1, 1'b1, 16'hA5C3, 4'd7);
        run(9, 1'b1);

        // 8001, A=15
        step(1'b1, 1'b1, 1'b1, 16'h8001, 4'd15);
        run(17, 1'b1);

        // single-bit word
        step(1'b1, 1'b1, 1'b1, 16'h0001, 4'd0);
        run(2, 1'b1);

        // CE gaps on an A=3 word
        step(1'b1, 1'b1, 1'b1, 16'h0009, 4'd3);
        step(1'b1, 1'b1, 1'b0, 16'h0, 4'h0);
        step(1'b1, 1'b0, 1'b0, 16'h0, 4'h0);
        step(1'b1, 1'b0, 1'b0, 16'h0, 4'h0);
        step(1'b1, 1'b1, 1'b0, 16'h0, 4'h0);
        step(1'b1, 1'b1, 1'b0, 16'h0, 4'h0);
        step(1'b1, 1'b0, 1'b0, 16'h0, 4'h0);
        step(1'b1, 1'b1, 1'b0, 16'h0, 4'h0);
        run(2, 1'b1);

        // back-to-back words offered at LAST
        step(1'b1, 1'b1, 1'b1, 16'h000A, 4'd3);
        run(3, 1'b1);
        step(1'b1, 1'b1, 1'b1, 16'h0005, 4'd3);
        run(5, 1'b1);

        // reset on the third bit of an A=7 word
        step(1'b1, 1'b1, 1'b1, 16'hA5C3, 4'd7);
        run(2, 1'b1);
        step(1'b0, 1'b1, 1'b0, 16'h0, 4'h0);
        run(2, 1'b1);

        // random words, lengths and enables
        for (int i = 0; i < 200; i++) begin
            step(1'b1, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 16'($urandom), 4'($urandom));
        end

        // bounded drain
        for (int i = 0; i < 40 && sb.size() != 0; i++) run(1, 1'b1);
        chk("drain_empty", 32'(sb.size()), 32'(0));
        run(1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
